// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage feeding the IF/ID pipeline register.
//
// Sends sequential fetch requests to a pipelined instruction memory. Returned
// words are buffered together with their PCs and presented to IF/ID one at a
// time under a valid/ready handshake. An EX-stage redirect flushes the queue.
// Responses that are still in flight at the redirect are counted and thrown
// away when they arrive.
//
// Ports:
//   i_clk, i_reset       clock (rising edge), synchronous active-low reset
//   o_imem_req/addr      fetch request and word-aligned address
//   i_imem_gnt           request accepted (transfer on req & gnt)
//   i_imem_rvalid/rdata  in-order response, at least one cycle after grant
//   o_valid/o_pc/o_instr queue head toward IF/ID
//   i_ready              IF/ID accepts head (pop on valid & ready)
//   i_redirect/_pc       redirect from EX, highest priority after reset
//   o_count              occupied queue entries
//
// Optional build macro FETCHQ_BYPASS_EN: when the queue is empty, a kept
// response is driven straight onto the head outputs in the same cycle. If IF/ID
// accepts it, it is never written. Without the macro every response is written
// first and becomes visible one cycle later.

module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  output logic                       o_imem_req,
  output logic [31:0]                o_imem_addr,
  input  logic                       i_imem_gnt,
  input  logic                       i_imem_rvalid,
  input  logic [31:0]                i_imem_rdata,
  output logic                       o_valid,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_instr,
  input  logic                       i_ready,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d;

  // Storage: instruction queue and in-flight PC tags
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];
  logic [31:0] tag_mem [MAX_OUTST];

  // Handshake decode
  logic        grant;
  logic        resp;
  logic        resp_keep;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] credit;
  logic [31:0] tag_pc;

  // The low address bits of a redirect target are ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTST - 1)) begin
      return '0;
    end
    return p + TW'(1);
  endfunction

  assign tag_pc = tag_mem[tag_rd_q];

  // A slot is reserved for every request that will really be kept. Dropped
  // responses never land, so they do not use up queue space.
  assign credit = 32'(count_q) + 32'(outst_q) - 32'(drop_q);

  assign o_imem_req  = i_reset & ~i_redirect & (32'(outst_q) < MAX_OUTST) & (credit < DEPTH);
  assign o_imem_addr = fetch_pc_q;
  assign o_count     = count_q;

  assign grant     = o_imem_req & i_imem_gnt;
  assign resp      = i_imem_rvalid;
  assign resp_keep = resp & (drop_q == '0) & ~i_redirect & i_reset;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = resp_keep & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that IF/ID takes right away is never stored.
  assign push = resp_keep & ~(bypass & i_ready);
  assign pop  = (count_q != '0) & i_ready & ~i_redirect;

  // Head outputs. These come from registers except for the optional bypass.
  // When the queue is empty they are forced to zero.
  always_comb begin
    o_valid = 1'b0;
    o_pc    = '0;
    o_instr = '0;
    if (bypass) begin
      o_valid = 1'b1;
      o_pc    = tag_pc;
      o_instr = i_imem_rdata;
    end else if (count_q != '0) begin
      o_valid = 1'b1;
      o_pc    = q_pc[rd_ptr_q];
      o_instr = q_instr[rd_ptr_q];
    end
  end

  // Next-state logic
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    // The tag FIFO follows the bus. It is not flushed by a redirect, because
    // dropped responses still consume their tags.
    if (resp) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end
    if (grant) begin
      tag_wr_d = tag_inc(tag_wr_q);
    end

    if (i_redirect) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
      // No grant can happen here. Whatever stays in flight after this cycle's
      // response is stale.
      outst_d    = outst_q - OW'(resp);
      drop_d     = outst_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      unique case ({grant, resp})
        2'b10:   outst_d = outst_q + OW'(1);
        2'b01:   outst_d = outst_q - OW'(1);
        default: outst_d = outst_q;
      endcase

      if (resp && (drop_q != '0)) begin
        drop_d = drop_q - OW'(1);
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Storage arrays. Their write enables are already qualified by reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= tag_pc;
      q_instr[wr_ptr_q] <= i_imem_rdata;
    end
    if (grant) begin
      tag_mem[tag_wr_q] <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. A small in-order instruction memory drives the DUT.
// A queue-based reference model predicts every output on every cycle, and
// directed sequences add literal expectations.

module tb_fetch_queue;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCHQ_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [2:0]  o_count;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .i_ready       (i_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_count       (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat_extra_max = 0;
  bit model_ok = 1'b0;

  // Memory environment: granted addresses with their earliest return cycle
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Reference model
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];
  logic [31:0] m_tags[$];
  logic [31:0] m_fetch;
  int          m_drop;

  // Expected values and DUT samples for the current cycle
  bit          e_req, e_valid, e_byp;
  logic [31:0] e_pc, e_instr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [2:0]  s_count;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle. Inputs are driven just after a rising edge and outputs are
  // compared at the falling edge. The model and memory advance on the next
  // rising edge.
  task automatic cycle(input bit rst_n, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input bit gnt, input bit rv_ok);
    logic [31:0] t;
    bit          keep, do_pop;
    i_reset       = rst_n;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_ready       = rdy;
    i_imem_gnt    = gnt;
    if (rst_n && rv_ok && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = word(pend_addr[0]);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end

    @(negedge i_clk);
    e_req = rst_n && !redir && (m_tags.size() < MAX_OUTST) &&
            (mq_pc.size() + m_tags.size() - m_drop < DEPTH);
    e_byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    e_byp = rst_n && !redir && i_imem_rvalid && m_drop == 0 && mq_pc.size() == 0 &&
            m_tags.size() > 0;
`endif
    if (e_byp) begin
      e_valid = 1'b1;
      e_pc    = m_tags[0];
      e_instr = word(m_tags[0]);
    end else begin
      e_valid = mq_pc.size() != 0;
      e_pc    = e_valid ? mq_pc[0] : 32'h0;
      e_instr = e_valid ? mq_in[0] : 32'h0;
    end
    s_req = o_imem_req;  s_addr  = o_imem_addr; s_valid = o_valid;
    s_pc  = o_pc;        s_instr = o_instr;     s_count = o_count;
    if (model_ok) begin
      chk("req", 32'(s_req), 32'(e_req));
      chk("valid", 32'(s_valid), 32'(e_valid));
      chk("count", 32'(s_count), 32'(mq_pc.size()));
      if (e_req) chk("addr", s_addr, m_fetch);
      if (e_valid) begin
        chk("pc", s_pc, e_pc);
        chk("instr", s_instr, e_instr);
      end
    end

    @(posedge i_clk);
    // Reference model update, straight from the functional rules
    if (!rst_n) begin
      mq_pc.delete(); mq_in.delete(); m_tags.delete();
      m_fetch  = RESET_PC;
      m_drop   = 0;
      model_ok = 1'b1;
    end else if (redir) begin
      if (i_imem_rvalid && m_tags.size() > 0) void'(m_tags.pop_front());
      mq_pc.delete(); mq_in.delete();
      m_fetch = {rpc[31:2], 2'b00};
      m_drop  = m_tags.size();
    end else begin
      keep   = 1'b0;
      do_pop = mq_pc.size() != 0 && rdy;
      t      = 32'h0;
      if (i_imem_rvalid && m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (m_drop > 0) m_drop--;
        else if (!(e_byp && rdy)) keep = 1'b1;
      end
      if (do_pop) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (keep) begin
        mq_pc.push_back(t);
        mq_in.push_back(word(t));
      end
      if (e_req && gnt) begin
        m_tags.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
      end
    end
    // Memory environment follows what the DUT actually did on the bus
    if (!rst_n) begin
      pend_addr.delete(); pend_due.delete();
    end else begin
      if (i_imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (s_req && gnt) begin
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc + 1 + int'($urandom_range(0, lat_extra_max)));
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] seen[3];
    logic [31:0] tgt;
    int          nseen, first_v;
    bit          rr, rd;

    // Reset state, then streaming with 1-cycle latency
    lat_extra_max = 0;
    do_reset();
    first_v = -1;
    nseen   = 0;
    seen    = '{32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_0000};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (i == 0) begin
        chk("rst_valid", 32'(s_valid), 32'h0);
        chk("rst_count", 32'(s_count), 32'h0);
        chk("rst_pc", s_pc, 32'h0);
        chk("rst_instr", s_instr, 32'h0);
        chk("rst_req", 32'(s_req), 32'h1);
        chk("rst_addr", s_addr, 32'h0);
      end
      if (s_valid && first_v < 0) first_v = i;
      if (s_valid && nseen < 3) begin
        seen[nseen] = s_pc;
        nseen++;
      end
    end
    chk("first_valid_cycle", 32'(first_v), 32'(FIRST_VALID));
    chk("stream_pc0", seen[0], 32'h0);
    chk("stream_pc1", seen[1], 32'h4);
    chk("stream_pc2", seen[2], 32'h8);

    // IF/ID stalled: queue fills, requests stop, head holds
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      if (s_valid) chk("stall_head_pc", s_pc, 32'h0);
    end
    chk("stall_count", 32'(s_count), 32'd4);
    chk("stall_req", 32'(s_req), 32'h0);
    chk("stall_instr", s_instr, word(32'h0));
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("full_again", 32'(s_count), 32'd4);
    // Reset with the queue full
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(s_valid), 32'h0);
    chk("mid_rst_count", 32'(s_count), 32'h0);
    chk("mid_rst_addr", s_addr, RESET_PC);

    // Grant stalled for three cycles: address holds
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("gnt_stall_addr", s_addr, 32'h8);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("gnt_resume_addr", s_addr, 32'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("gnt_next_addr", s_addr, 32'hC);

    // Redirect with two requests in flight
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    chk("redir_no_req", 32'(s_req), 32'h0);
    nseen = 0;
    seen  = '{32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_0000};
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (s_valid && nseen < 3) begin
        seen[nseen] = s_pc;
        nseen++;
      end
    end
    chk("redir_first_pc", seen[0], 32'h100);
    chk("redir_second_pc", seen[1], 32'h104);

    // Redirect to an unaligned target, together with a response and a pop
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h203, 1'b1, 1'b1, 1'b1);
    chk("redir2_rvalid_seen", 32'(i_imem_rvalid), 32'h1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("redir2_count", 32'(s_count), 32'h0);
    chk("redir2_valid", 32'(s_valid), 32'h0);
    chk("redir2_req", 32'(s_req), 32'h1);
    chk("redir2_addr", s_addr, 32'h200);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic against the model
    lat_extra_max = 2;
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 99) < 4);
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
      cycle(!rr, rd, tgt, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 80);
    end

    // Address wrap after a redirect near the top of the address space
    nseen = 0;
    seen  = '{32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_0000};
    cycle(1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      if (s_valid && nseen < 3) begin
        seen[nseen] = s_pc;
        nseen++;
      end
    end
    chk("wrap_pc0", seen[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", seen[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", seen[2], 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
